// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared frogger types, key codes and playfield constants
package frogger_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOP    = 2'd1,
        LANDED = 2'd2
    } motion_state_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam int GRID_PX    = 32;
    localparam int HOP_FRAMES_N = 8;
    localparam int X_START_PX = 304;
    localparam int Y_START_PX = 448;
    localparam int X_MAX_PX   = 608;
    localparam int Y_MIN_PX   = 32;
    localparam int Y_MAX_PX   = 448;

endpackage

// File: rtl/frog_key_decoder.sv
// rtl/frog_key_decoder.sv - maps a USB keycode onto a hop direction
module frog_key_decoder
    import frogger_pkg::*;
(
    input  logic [7:0] keycode,
    output logic       valid,
    output dir_t       dir
);

    always_comb begin
        valid = 1'b1;
        dir   = UP;
        case (keycode)
            KEY_W:   dir = UP;
            KEY_S:   dir = DOWN;
            KEY_A:   dir = LEFT;
            KEY_D:   dir = RIGHT;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/frog_motion.sv
// rtl/frog_motion.sv - frog hop state machine, ride drift and playfield clamp
module frog_motion
    import frogger_pkg::*;
#(
    parameter int GRID       = GRID_PX,
    parameter int HOP_FRAMES = HOP_FRAMES_N,
    parameter int X_START    = X_START_PX,
    parameter int Y_START    = Y_START_PX,
    parameter int X_MAX      = X_MAX_PX,
    parameter int Y_MIN      = Y_MIN_PX,
    parameter int Y_MAX      = Y_MAX_PX
) (
    input  logic       frame_clk,
    input  logic       game_restart_n,
    input  logic [7:0] keycode,
    input  logic       respawn,
    input  logic       freeze,
    input  logic [3:0] ride_dx,
    output logic [9:0] Frog_X,
    output logic [9:0] Frog_Y,
    output logic [1:0] frog_dir,
    output logic       hopping,
    output logic       hop_done,
    output logic       edge_death
);

    localparam int STEP = GRID / HOP_FRAMES;
    // One extra bit: the count runs HOP_FRAMES-1 down past zero, and the
    // wrap (MSB set) marks the frame after the last step, which enters LANDED.
    localparam int CW = $clog2(HOP_FRAMES) + 1;

    motion_state_t state, state_nx;
    dir_t          dir, dir_nx, key_dir;
    logic [CW-1:0] hop_cnt, cnt_nx;
    logic          key_armed, armed_nx, key_valid, legal;
    logic [9:0]    x_nx, y_nx;
    logic          hop_done_nx, edge_death_nx;
    logic [11:0]   drift_sum;

    frog_key_decoder u_key_decoder (
        .keycode (keycode),
        .valid   (key_valid),
        .dir     (key_dir)
    );

    assign frog_dir  = dir;
    assign drift_sum = {2'b00, Frog_X} + {{8{ride_dx[3]}}, ride_dx};

    always_comb begin
        legal = 1'b0;
        case (key_dir)
            UP:      legal = (Frog_Y >= 10'(Y_MIN + GRID));
            DOWN:    legal = (Frog_Y <= 10'(Y_MAX - GRID));
            LEFT:    legal = (Frog_X >= 10'(GRID));
            RIGHT:   legal = (Frog_X <= 10'(X_MAX - GRID));
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = hop_cnt;
        armed_nx      = key_armed;
        dir_nx        = dir;
        x_nx          = Frog_X;
        y_nx          = Frog_Y;
        hop_done_nx   = 1'b0;
        edge_death_nx = 1'b0;
        case (state)
            IDLE: begin
                if (key_valid && key_armed) begin
                    dir_nx   = key_dir;
                    armed_nx = 1'b0;
                end
                if (key_valid && key_armed && legal) begin
                    state_nx = HOP;
                    cnt_nx   = CW'(HOP_FRAMES - 1);
                end else if (drift_sum[11]) begin
                    x_nx          = 10'd0;
                    edge_death_nx = 1'b1;
                end else if (drift_sum > 12'(X_MAX)) begin
                    x_nx          = 10'(X_MAX);
                    edge_death_nx = 1'b1;
                end else begin
                    x_nx = drift_sum[9:0];
                end
            end
            HOP: begin
                if (hop_cnt[CW-1]) begin
                    state_nx    = LANDED;
                    hop_done_nx = 1'b1;
                end else begin
                    cnt_nx = hop_cnt - CW'(1);
                    case (dir)
                        UP:      y_nx = Frog_Y - 10'(STEP);
                        DOWN:    y_nx = Frog_Y + 10'(STEP);
                        LEFT:    x_nx = Frog_X - 10'(STEP);
                        default: x_nx = Frog_X + 10'(STEP);
                    endcase
                end
            end
            default: state_nx = IDLE;
        endcase
        if (!key_valid) begin
            armed_nx = 1'b1;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!game_restart_n || respawn) begin
            state      <= IDLE;
            hop_cnt    <= '0;
            key_armed  <= 1'b0;
            dir        <= UP;
            Frog_X     <= 10'(X_START);
            Frog_Y     <= 10'(Y_START);
            hopping    <= 1'b0;
            hop_done   <= 1'b0;
            edge_death <= 1'b0;
        end else if (freeze) begin
            hop_done   <= 1'b0;
            edge_death <= 1'b0;
        end else begin
            state      <= state_nx;
            hop_cnt    <= cnt_nx;
            key_armed  <= armed_nx;
            dir        <= dir_nx;
            Frog_X     <= x_nx;
            Frog_Y     <= y_nx;
            hopping    <= (state_nx == HOP);
            hop_done   <= hop_done_nx;
            edge_death <= edge_death_nx;
        end
    end

endmodule

// File: tb/tb_frog_motion.sv
// tb/tb_frog_motion.sv - randomized self-checking bench for frog_motion
module tb_frog_motion;
    import frogger_pkg::*;

    logic       frame_clk = 1'b0;
    logic       game_restart_n = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       respawn = 1'b0;
    logic       freeze = 1'b0;
    logic [3:0] ride_dx = 4'h0;
    logic [9:0] Frog_X, Frog_Y;
    logic [1:0] frog_dir;
    logic       hopping, hop_done, edge_death;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: hop progress is tracked as frames since the key was taken
    // (0 = standing), and hop positions are origin + direction * 4 * frames.
    int m_x, m_y, m_dir, m_age, m_ox, m_oy;
    bit m_armed, m_hd, m_ed;

    frog_motion dut (
        .frame_clk      (frame_clk),
        .game_restart_n (game_restart_n),
        .keycode        (keycode),
        .respawn        (respawn),
        .freeze         (freeze),
        .ride_dx        (ride_dx),
        .Frog_X         (Frog_X),
        .Frog_Y         (Frog_Y),
        .frog_dir       (frog_dir),
        .hopping        (hopping),
        .hop_done       (hop_done),
        .edge_death     (edge_death)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic int key_to_dir(input logic [7:0] k);
        if (k == 8'h1A) return 0;
        if (k == 8'h16) return 1;
        if (k == 8'h04) return 2;
        if (k == 8'h07) return 3;
        return -1;
    endfunction

    function automatic int vx(input int d);
        return (d == 2) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    function automatic int vy(input int d);
        return (d == 0) ? -1 : (d == 1) ? 1 : 0;
    endfunction

    task automatic model_edge();
        int kd, tx, ty, s;
        bit took;
        kd = key_to_dir(keycode);
        took = 1'b0;
        if (!game_restart_n || respawn) begin
            m_x = 304; m_y = 448; m_dir = 0; m_age = 0;
            m_armed = 0; m_hd = 0; m_ed = 0;
        end else if (freeze) begin
            m_hd = 0; m_ed = 0;
        end else begin
            m_hd = 0; m_ed = 0;
            if (m_age == 0) begin
                if (kd >= 0 && m_armed) begin
                    m_dir = kd;
                    m_armed = 0;
                    tx = m_x + 32 * vx(kd);
                    ty = m_y + 32 * vy(kd);
                    if (tx >= 0 && tx <= 608 && ty >= 32 && ty <= 448) begin
                        took = 1'b1; m_age = 1; m_ox = m_x; m_oy = m_y;
                    end
                end
                if (!took) begin
                    s = m_x + int'($signed(ride_dx));
                    if (s < 0) begin m_x = 0; m_ed = 1; end
                    else if (s > 608) begin m_x = 608; m_ed = 1; end
                    else m_x = s;
                end
            end else if (m_age < 9) begin
                m_age++;
                m_x = m_ox + 4 * (m_age - 1) * vx(m_dir);
                m_y = m_oy + 4 * (m_age - 1) * vy(m_dir);
            end else if (m_age == 9) begin
                m_age = 10; m_hd = 1;
            end else begin
                m_age = 0;
            end
            if (kd < 0) m_armed = 1;
        end
    endtask

    function automatic logic [24:0] obs();
        return {Frog_X, Frog_Y, frog_dir, hopping, hop_done, edge_death};
    endfunction

    function automatic logic [24:0] expv();
        logic h;
        h = (m_age >= 1 && m_age <= 9);
        return {10'(m_x), 10'(m_y), 2'(m_dir), h, m_hd, m_ed};
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        model_edge();
        @(negedge frame_clk);
    endtask

    task automatic test_reset();
        game_restart_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs() !== 25'({10'd304, 10'd448, 2'd0, 3'b000})) begin
                miscompares++;
                $display("FAIL reset: got %h want %h", obs(), 25'({10'd304, 10'd448, 2'd0, 3'b000}));
            end
        end
        game_restart_n = 1'b1;
    endtask

    task automatic test_first_hop();
        keycode = 8'h00;
        tick();
        keycode = KEY_W;
        for (int i = 0; i < 14; i++) begin
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL first_hop model i=%0d: got %h want %h", i, obs(), expv());
            end
            if (i >= 1 && i <= 8) begin
                vectors++;
                if (Frog_Y !== 10'(448 - 4 * i)) begin
                    miscompares++;
                    $display("FAIL first_hop y i=%0d: got %0d want %0d", i, Frog_Y, 448 - 4 * i);
                end
            end
            vectors++;
            if (hop_done !== (i == 9)) begin
                miscompares++;
                $display("FAIL first_hop hop_done i=%0d: got %0b want %0b", i, hop_done, (i == 9));
            end
        end
        vectors++;
        if ({Frog_Y, hopping} !== {10'd416, 1'b0}) begin
            miscompares++;
            $display("FAIL held_no_repeat: got y=%0d hop=%0b want y=416 hop=0", Frog_Y, hopping);
        end
    endtask

    task automatic test_home_row();
        for (int h = 0; h < 13; h++) begin
            keycode = 8'h00;
            tick();
            keycode = (h == 12) ? KEY_A : KEY_W;
            for (int i = 0; i < 11; i++) begin
                tick();
                vectors++;
                if (obs() !== expv()) begin
                    miscompares++;
                    $display("FAIL climb h=%0d i=%0d: got %h want %h", h, i, obs(), expv());
                end
            end
        end
        keycode = 8'h00;
        tick();
        keycode = KEY_W;
        tick();
        vectors++;
        if ({Frog_X, Frog_Y, frog_dir, hopping} !== {10'd272, 10'd32, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL home_row_reject: got x=%0d y=%0d dir=%0d hop=%0b want 272 32 0 0",
                     Frog_X, Frog_Y, frog_dir, hopping);
        end
        tick();
        keycode = KEY_S;
        tick();
        tick();
        vectors++;
        if ({Frog_Y, frog_dir, hopping} !== {10'd32, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL armed_cleared: got y=%0d dir=%0d hop=%0b want 32 0 0", Frog_Y, frog_dir, hopping);
        end
    endtask

    task automatic drift_run(input logic [3:0] d, input int n);
        ride_dx = d;
        for (int i = 0; i < n; i++) begin
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL drift dx=%0h i=%0d: got %h want %h", d, i, obs(), expv());
            end
        end
    endtask

    task automatic test_edge_drift();
        keycode = 8'h00;
        respawn = 1'b1;
        tick();
        respawn = 1'b0;
        drift_run(4'h8, 37);
        drift_run(4'hC, 1);
        vectors++;
        if (Frog_X !== 10'd4) begin
            miscompares++;
            $display("FAIL drift_setup_left: got %0d want 4", Frog_X);
        end
        drift_run(4'h8, 1);
        vectors++;
        if ({Frog_X, edge_death} !== {10'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL edge_left: got x=%0d ed=%0b want x=0 ed=1", Frog_X, edge_death);
        end
        drift_run(4'h0, 1);
        vectors++;
        if (edge_death !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_pulse_width: got %0b want 0", edge_death);
        end
        drift_run(4'h7, 86);
        drift_run(4'h3, 1);
        vectors++;
        if (Frog_X !== 10'd605) begin
            miscompares++;
            $display("FAIL drift_setup_right: got %0d want 605", Frog_X);
        end
        drift_run(4'h7, 1);
        vectors++;
        if ({Frog_X, edge_death} !== {10'd608, 1'b1}) begin
            miscompares++;
            $display("FAIL edge_right: got x=%0d ed=%0b want x=608 ed=1", Frog_X, edge_death);
        end
        ride_dx = 4'h0;
    endtask

    task automatic test_respawn_mid_hop();
        int seen;
        keycode = 8'h00;
        respawn = 1'b1;
        tick();
        respawn = 1'b0;
        tick();
        keycode = KEY_W;
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (Frog_Y !== 10'd432) begin
            miscompares++;
            $display("FAIL hop_frame4: got y=%0d want 432", Frog_Y);
        end
        respawn = 1'b1;
        tick();
        respawn = 1'b0;
        vectors++;
        if ({Frog_X, Frog_Y, frog_dir, hopping} !== {10'd304, 10'd448, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL respawn_abort: got x=%0d y=%0d dir=%0d hop=%0b want 304 448 0 0",
                     Frog_X, Frog_Y, frog_dir, hopping);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (hop_done) seen++;
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL after_respawn i=%0d: got %h want %h", i, obs(), expv());
            end
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL respawn_no_hop_done: got %0d pulses want 0", seen);
        end
    endtask

    task automatic test_freeze();
        int t, done_at;
        logic [9:0] y_hold;
        keycode = 8'h00;
        tick();
        keycode = KEY_W;
        tick();
        t = 0;
        done_at = -1;
        for (int i = 0; i < 3; i++) begin tick(); t++; end
        y_hold = Frog_Y;
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); t++;
            vectors++;
            if ({Frog_Y, hopping} !== {y_hold, 1'b1}) begin
                miscompares++;
                $display("FAIL freeze_hold i=%0d: got y=%0d hop=%0b want y=%0d hop=1", i, Frog_Y, hopping, y_hold);
            end
        end
        freeze = 1'b0;
        while (done_at < 0 && t < 30) begin
            tick(); t++;
            if (hop_done === 1'b1) done_at = t;
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL freeze_resume t=%0d: got %h want %h", t, obs(), expv());
            end
        end
        vectors++;
        if (done_at != 14) begin
            miscompares++;
            $display("FAIL freeze_hop_done_delay: got %0d want 14", done_at);
        end
    endtask

    task automatic test_right_wall();
        logic [9:0] px;
        keycode = 8'h00;
        respawn = 1'b1;
        tick();
        respawn = 1'b0;
        drift_run(4'h7, 44);
        ride_dx = 4'h0;
        keycode = KEY_D;
        tick();
        vectors++;
        if ({Frog_X, frog_dir, hopping} !== {10'd608, 2'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL right_wall: got x=%0d dir=%0d hop=%0b want 608 3 0", Frog_X, frog_dir, hopping);
        end
        keycode = 8'h00;
        respawn = 1'b1;
        tick();
        respawn = 1'b0;
        tick();
        keycode = KEY_D;
        tick();
        for (int i = 0; i < 8; i++) begin
            px = Frog_X;
            ride_dx = 4'($urandom_range(1, 15));
            tick();
            vectors++;
            if (Frog_X !== px + 10'd4) begin
                miscompares++;
                $display("FAIL hop_ignores_drift i=%0d: got %0d want %0d", i, Frog_X, px + 10'd4);
            end
        end
        ride_dx = 4'h0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_random();
        int r;
        keycode = 8'h00;
        respawn = 1'b1;
        tick();
        respawn = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: keycode = 8'h00;
                3:       keycode = KEY_W;
                4:       keycode = KEY_S;
                5:       keycode = KEY_A;
                6:       keycode = KEY_D;
                7:       keycode = 8'($urandom);
                default: keycode = keycode;
            endcase
            ride_dx = 4'($urandom);
            freeze  = ($urandom_range(0, 19) == 0);
            respawn = ($urandom_range(0, 59) == 0);
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random i=%0d: got %h want %h", i, obs(), expv());
            end
        end
        freeze = 1'b0;
        respawn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_hop();
        test_home_row();
        test_edge_drift();
        test_respawn_mid_hop();
        test_freeze();
        test_right_wall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
